// File: rtl/ascii_dec_parser.sv
// rtl/ascii_dec_parser.sv - ASCII decimal line parser (optional signed parsing via PARSER_SIGN_EN)
module ascii_dec_parser #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] num_out,
  output logic             num_valid,
  output logic             num_error,
  output logic             busy
);

  // One spare bit above the WIDTH+4 accumulator so acc*10+9 never wraps.
  localparam int AW = WIDTH + 5;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAXD = CW'(MAX_DIGITS);
`ifdef PARSER_SIGN_EN
  localparam logic [AW-1:0] POS_MAX = (AW'(1) << (WIDTH - 1)) - AW'(1);
  localparam logic [AW-1:0] NEG_MAX = AW'(1) << (WIDTH - 1);
`else
  localparam logic [AW-1:0] UMAX = (AW'(1) << WIDTH) - AW'(1);
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

  state_t           state_q, state_d;
  logic [AW-2:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
`ifdef PARSER_SIGN_EN
  logic             neg_q, neg_d;
`endif

  logic          is_digit, is_term, is_space, over;
  logic [AW-1:0] acc_ext, acc_next;

  // Byte classification and the candidate accumulator value for a digit.
  always_comb begin
    is_digit = (rx_data >= 8'd48) && (rx_data <= 8'd57);
    is_term  = (rx_data == 8'd13) || (rx_data == 8'd10);
    is_space = (rx_data == 8'd32);
    acc_ext  = {1'b0, acc_q};
    acc_next = (acc_ext << 3) + (acc_ext << 1) + {{(AW-4){1'b0}}, rx_data[3:0]};
`ifdef PARSER_SIGN_EN
    over     = neg_q ? (acc_next > NEG_MAX) : (acc_next > POS_MAX);
`else
    over     = acc_next > UMAX;
`endif
  end

  // Next-state logic: only a strobed byte may change the line state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef PARSER_SIGN_EN
    neg_d   = neg_q;
`endif
    if (rx_valid) begin
      case (state_q)
        IDLE, ACCUM: begin
          if (is_digit) begin
            if ((cnt_q >= MAXD) || over) begin
              state_d = DISCARD;
            end else begin
              acc_d   = acc_next[AW-2:0];
              cnt_d   = cnt_q + CW'(1);
              state_d = ACCUM;
            end
          end else if (is_term) begin
            // A terminator in IDLE is an empty line or the LF of a CRLF pair.
            if (state_q == ACCUM) begin
              if (cnt_q != '0) begin
`ifdef PARSER_SIGN_EN
                num_d = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
`else
                num_d = acc_q[WIDTH-1:0];
`endif
                valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
              state_d = IDLE;
              acc_d   = '0;
              cnt_d   = '0;
`ifdef PARSER_SIGN_EN
              neg_d   = 1'b0;
`endif
            end
          end else if (is_space) begin
            if (state_q == ACCUM) state_d = DISCARD;
          end
`ifdef PARSER_SIGN_EN
          else if ((rx_data == 8'd45) && (state_q == IDLE)) begin
            neg_d   = 1'b1;
            state_d = ACCUM;
          end
`endif
          else begin
            state_d = DISCARD;
          end
        end
        default: begin
          if (is_term) begin
            err_d   = 1'b1;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef PARSER_SIGN_EN
            neg_d   = 1'b0;
`endif
          end
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef PARSER_SIGN_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef PARSER_SIGN_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Output mapping.
  always_comb begin
    num_out   = num_q;
    num_valid = valid_q;
    num_error = err_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_ascii_dec_parser.sv
// tb/tb_ascii_dec_parser.sv - directed self-checking bench for ascii_dec_parser
module tb_ascii_dec_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] num_out;
  logic       num_valid, num_error, busy;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;
  logic both_seen = 1'b0;

  ascii_dec_parser #(.WIDTH(8), .MAX_DIGITS(3)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .num_out(num_out), .num_valid(num_valid), .num_error(num_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (num_valid) vcnt++;
      if (num_error) ecnt++;
      if (num_valid && num_error) both_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h78;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) drive(s[i]);
  endtask

  task automatic idle_clear();
    repeat (2) @(negedge clk);
    vcnt = 0;
    ecnt = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_num_out", num_out, 0);
    check("rst_valid", num_valid, 0);
    check("rst_error", num_error, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    idle_clear();

    send("123");
    check("busy_mid", busy, 1);
    drive(8'd13);
    check("123_valid_t1", num_valid, 1);
    check("123_out", num_out, 123);
    @(negedge clk);
    check("123_valid_t2", num_valid, 0);
    check("123_vcnt", vcnt, 1);
    check("123_ecnt", ecnt, 0);
    idle_clear();

    send("007\n");
    idle_clear();
    check("007_out", num_out, 7);

    send("1234\n");
    send("12a\n");
    idle_clear();
    check("bad_out_hold", num_out, 7);

    send("9\n");
    send("\n\015");
    idle_clear();
    check("9_out", num_out, 9);

    vcnt = 0; ecnt = 0;
    send("1234\n12a\n");
    repeat (2) @(negedge clk);
    check("bad_ecnt", ecnt, 2);
    check("bad_vcnt", vcnt, 0);
    idle_clear();

    send(" 42\n");
    repeat (2) @(negedge clk);
    check("space_lead_out", num_out, 42);
    check("space_lead_vcnt", vcnt, 1);
    idle_clear();
    send("4 2\n");
    repeat (2) @(negedge clk);
    check("space_mid_ecnt", ecnt, 1);
    check("space_mid_out", num_out, 42);
    idle_clear();

    drive("6");
    repeat (3) @(negedge clk);
    check("gap_busy", busy, 1);
    send("1\n");
    idle_clear();
    check("gap_out", num_out, 61);

    send("42");
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out", num_out, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_vcnt", vcnt, 0);
    check("midrst_ecnt", ecnt, 0);
    send("5\n");
    idle_clear();
    check("after_rst_out", num_out, 5);

`ifdef PARSER_SIGN_EN
    send("-128\n");
    repeat (2) @(negedge clk);
    check("neg128_out", num_out, 32'h80);
    check("neg128_vcnt", vcnt, 1);
    idle_clear();
    send("-129\n200\n-\n12-\n");
    repeat (2) @(negedge clk);
    check("sign_bad_ecnt", ecnt, 4);
    check("sign_bad_vcnt", vcnt, 0);
    check("sign_bad_out", num_out, 32'h80);
    idle_clear();
    send("127\n");
    idle_clear();
    check("pos127_out", num_out, 127);
`else
    send("255\015\n");
    repeat (2) @(negedge clk);
    check("255_out", num_out, 255);
    check("255_vcnt", vcnt, 1);
    check("255_ecnt", ecnt, 0);
    idle_clear();
    send("256\n");
    repeat (2) @(negedge clk);
    check("256_ecnt", ecnt, 1);
    check("256_out", num_out, 255);
    idle_clear();
    send("-5\n");
    repeat (2) @(negedge clk);
    check("minus_ecnt", ecnt, 1);
    check("minus_vcnt", vcnt, 0);
    check("minus_out", num_out, 255);
    idle_clear();
`endif

    check("never_both", both_seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_dec_parser.md
ASCII_DEC_PARSER -- requirements
Module: ascii_dec_parser

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning bit width of the parsed binary result.
REQ-002 The module SHALL have parameter MAX_DIGITS, default 3, meaning the maximum number of decimal digits accepted per line.
REQ-003 Port clk  input  1  meaning single system clock; all state SHALL change on its rising edge.
REQ-004 Port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 Port rx_data  input  8  meaning received ASCII byte, sampled only when rx_valid=1.
REQ-006 Port rx_valid  input  1  meaning one-cycle strobe from the UART receiver's data_ready.
REQ-007 Port num_out  output  WIDTH  meaning last successfully parsed value.
REQ-008 Port num_valid  output  1  meaning one-cycle pulse when num_out is updated.
REQ-009 Port num_error  output  1  meaning one-cycle pulse when a line is rejected.
REQ-010 Port busy  output  1  meaning a line is partially received (state not IDLE).

Function
REQ-011 The state machine SHALL have states IDLE, ACCUM and DISCARD.
REQ-012 A digit '0'-'9' (48-57) in IDLE or ACCUM SHALL update acc = acc*10 + (rx_data-48), increment digit count and enter/stay in ACCUM.
REQ-013 The accumulator SHALL be at least WIDTH+4 bits wide so overflow is detected, never wrapped.
REQ-014 A digit that makes digit count exceed MAX_DIGITS or acc exceed 2^WIDTH-1 SHALL move the FSM to DISCARD.
REQ-015 Any byte other than digit, CR (13), LF (10) or space (32) in IDLE/ACCUM SHALL move the FSM to DISCARD.
REQ-016 Space in IDLE SHALL be ignored; space in ACCUM SHALL move the FSM to DISCARD.
REQ-017 CR or LF in ACCUM with at least one digit SHALL load num_out with acc, assert num_valid the next cycle for exactly one cycle, and return to IDLE.
REQ-018 CR or LF in DISCARD SHALL assert num_error the next cycle for exactly one cycle, leave num_out unchanged, and return to IDLE.
REQ-019 CR or LF in IDLE (empty line, LF following CR) SHALL produce no pulse.
REQ-020 In DISCARD all non-terminator bytes SHALL be ignored.
REQ-021 num_valid and num_error SHALL never be asserted in the same cycle.
REQ-022 Cycles with rx_valid=0 SHALL leave all state unchanged; back-to-back rx_valid on consecutive cycles SHALL be processed without loss.
REQ-023 num_out SHALL hold its value until the next num_valid.

Reset
REQ-024 Reset SHALL immediately force state IDLE, acc 0, digit count 0, num_out 0, num_valid 0, num_error 0, busy 0.
REQ-025 Reset mid-line SHALL discard the partial line with no pulse; parsing resumes with the first byte after reset deasserts.

Configuration
REQ-026 Macro PARSER_SIGN_EN SHALL enable signed parsing; when undefined, behaviour SHALL be unsigned as above.
REQ-027 With PARSER_SIGN_EN, '-' (45) in IDLE SHALL set a negative flag and enter ACCUM with zero digits; '-' anywhere else SHALL move the FSM to DISCARD.
REQ-028 With PARSER_SIGN_EN, accepted range SHALL be -2^(WIDTH-1)..2^(WIDTH-1)-1, out-of-range SHALL enter DISCARD, num_out SHALL be two's complement, and a terminator after a lone '-' SHALL raise num_error.
REQ-029 Without PARSER_SIGN_EN, '-' SHALL be treated as an invalid character (REQ-015).

Verification (WIDTH=8, MAX_DIGITS=3)
REQ-030 "123\r" -> num_out=8'd123, num_valid high exactly one cycle after the CR strobe, num_error never high.
REQ-031 "255\r\n" -> single num_valid with num_out=255; LF produces nothing; "007\n" -> num_out=7.
REQ-032 "256\n" then "1234\n" then "12a\n" -> three num_error pulses, no num_valid, num_out keeps prior value; following "9\n" -> num_out=9.
REQ-033 Bytes "4","2" on consecutive cycles, reset asserted mid-line -> busy=0 immediately, no pulses; then "5\n" -> num_out=5.
REQ-034 PARSER_SIGN_EN defined: "-128\n" -> num_out=8'h80; "-129\n" and "200\n" -> num_error; "-\n" -> num_error; "12-\n" -> num_error.
REQ-035 PARSER_SIGN_EN undefined: "-5\n" -> num_error, num_out unchanged.
